mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch (IF) port and data (MEM-stage load/store) port.
- Grants one requester at a time and drives the memory bus.
- Returns read data and a one-cycle done pulse to the requester.
- Produces stall signals that freeze the pipeline while an access is outstanding; sits between the pipelined core and the memory model.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
STARVE_MAX, 4, consecutive data grants allowed while IF is waiting before IF is forced to win
TIMEOUT, 64, cycles allowed between mem_en assertion and mem_valid before the access is aborted

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
if_req  input  1  fetch request; held high with if_addr stable until if_done
if_addr  input  ADDR_W  fetch address
if_rdata  output  DATA_W  fetched instruction, valid while if_done=1
if_done  output  1  one-cycle completion pulse for fetch
if_stall  output  1  if_req & ~if_done
d_req  input  1  data request; held with d_we/d_addr/d_wdata/d_be stable until d_done
d_we  input  1  1=store, 0=load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_be  input  DATA_W/8  byte enables for stores
d_rdata  output  DATA_W  load data, valid while d_done=1
d_done  output  1  one-cycle completion pulse for data
d_stall  output  1  d_req & ~d_done
mem_en  output  1  memory access active
mem_we  output  1  memory write
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_be  output  DATA_W/8  memory byte enables
mem_rdata  input  DATA_W  memory read data, valid with mem_valid
mem_valid  input  1  one-cycle completion from memory
bus_err  output  1  sticky timeout flag

Behaviour:
- Reset:
  - State is IDLE.
  - All outputs are 0, including bus_err, if_rdata and d_rdata.
  - Starvation and timeout counters are 0.
  - Reset asserted mid-access abandons the access immediately; no done pulse is issued; mem_en drops in the cycle after rst is sampled.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE, arbitration on the sampled request lines:
  - d_req only -> BUSY_D.
  - if_req only -> BUSY_I.
  - Both requests: data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - Neither request: stay in IDLE.
- starve_cnt:
  - Increments on each data grant while if_req=1.
  - Clears on any fetch grant, and on any data grant while if_req=0.
  - Saturates at STARVE_MAX.
- BUSY_x drive rules:
  - mem_en=1; mem_addr, mem_we, mem_wdata, mem_be are registered from the granted port at grant.
  - Fetch grants drive mem_we=0 and mem_be all ones.
  - All of these hold constant until completion.
- Completion:
  - On mem_valid, mem_rdata is registered into x_rdata.
  - x_done pulses in the following cycle and the state returns to IDLE that same cycle.
  - mem_en deasserts in the cycle x_done is high.
  - Store completion also pulses d_done; d_rdata is then don't-care but is driven 0.
- Latency:
  - Request seen in IDLE at cycle N -> mem_en high at N+1.
  - mem_valid at cycle M -> done at M+1.
  - Back-to-back throughput is one access per (memory latency + 2) cycles.
  - A requester dropping req without receiving done is illegal; this is not checked.
- Timeout:
  - The counter increments each BUSY cycle and resets on entering BUSY.
  - If it reaches TIMEOUT without mem_valid, the arbiter sets bus_err=1 (sticky until rst), pulses x_done with x_rdata=0, and returns to IDLE.
  - mem_valid arriving in the same cycle the count hits TIMEOUT is treated as a normal completion; no error is raised.
- mem_valid while in IDLE is ignored.
- Requests arriving during BUSY wait their turn; x_stall stays high.
- Stall signals are combinational from req and done.

Decomposition:
- Shared package riscv_pkg holds:
  - arbiter state encoding (ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D);
  - default ADDR_W/DATA_W constants;
  - the port-id constants used in assertions.
- One natural sub-module: arb_timeout_ctr, a loadable up-counter with terminal-count output, parameterized by TIMEOUT.
- Starvation logic stays inline.

Test Plan:
- Fetch only, memory latency 2: if_req at cycle 5, addr 0x10 -> mem_en at cycle 6, mem_valid at cycle 8 with 0x00500093 -> if_done at cycle 9 with if_rdata=0x00500093; if_stall high for cycles 5-8.
- Simultaneous if_req and d_req, d_we=1, addr 0x100, data 0xDEADBEEF, be=0xF -> data granted first with mem_we=1, d_done pulses, then fetch is granted on the next IDLE cycle.
- d_req held continuously for 6 accesses with if_req pending, STARVE_MAX=4 -> data, data, data, data, then fetch, then data; if_done observed after exactly 4 data completions.
- Memory never asserts mem_valid, TIMEOUT=64 -> d_done with d_rdata=0 at grant+64 cycles; bus_err=1 and stays 1 until rst.
- rst asserted in BUSY_I one cycle before mem_valid -> no if_done pulse; all outputs 0 the next cycle; bus_err cleared.
- mem_valid pulsed while IDLE with no requests -> no done pulses and no state change.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the memory arbiter slice: state encoding,
// default bus widths and the requester identifiers.
package riscv_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   // Requester identifiers
   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSY_I = 2'd1,
      ARB_BUSY_D = 2'd2
   } arb_state_t;

   // Which requester owns the bus in a given arbiter state
   function automatic logic port_of(input arb_state_t s);
      return (s == ARB_BUSY_D) ? PORT_D : PORT_I;
   endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Loadable up-counter that measures how long the current memory access
// has been outstanding. tc flags the cycle in which the next increment
// reaches TIMEOUT, so the owner can abort on that same clock edge.
module arb_timeout_ctr
   import riscv_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic tc
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Clear on load, otherwise count enabled cycles and park at TIMEOUT
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = '0;
      end else if (en && (count_q != CW'(TIMEOUT))) begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and
// the data port. One access is in flight at a time; data normally wins,
// but fetch is forced through after STARVE_MAX back-to-back data grants.
// A watchdog aborts accesses the memory never answers and latches bus_err.
module mem_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_done,
   output logic                if_stall,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_done,
   output logic                d_stall,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_valid,
   output logic                bus_err
);

   localparam int BE_W = DATA_W / 8;
   localparam int SW   = $clog2(STARVE_MAX + 1);

   arb_state_t        state_q,     state_d;
   logic [SW-1:0]     starve_q,    starve_d;
   logic              mem_en_q,    mem_en_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [BE_W-1:0]   mem_be_q,    mem_be_d;
   logic              if_done_q,   if_done_d;
   logic              d_done_q,    d_done_d;
   logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
   logic              bus_err_q,   bus_err_d;

   logic tmo_load;
   logic tmo_en;
   logic tmo_tc;
   logic starved;

   assign starved = (starve_q == SW'(STARVE_MAX));

   arb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk  (clk),
      .rst  (rst),
      .load (tmo_load),
      .en   (tmo_en),
      .tc   (tmo_tc)
   );

   // Arbitration, bus capture at grant, and completion/abort handling
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      if_done_d   = 1'b0;
      d_done_d    = 1'b0;
      if_rdata_d  = '0;
      d_rdata_d   = '0;
      bus_err_d   = bus_err_q;
      tmo_load    = 1'b0;
      tmo_en      = 1'b0;

      unique case (state_q)
         ARB_IDLE: begin
            if (d_req && !(if_req && starved)) begin
               state_d     = ARB_BUSY_D;
               mem_en_d    = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_be_d    = d_be;
               tmo_load    = 1'b1;
               if (!if_req) begin
                  starve_d = '0;
               end else if (!starved) begin
                  starve_d = starve_q + 1'b1;
               end
            end else if (if_req) begin
               state_d     = ARB_BUSY_I;
               mem_en_d    = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
               mem_be_d    = '1;
               tmo_load    = 1'b1;
               starve_d    = '0;
            end
         end

         ARB_BUSY_I, ARB_BUSY_D: begin
            tmo_en = 1'b1;
            if (mem_valid || tmo_tc) begin
               state_d  = ARB_IDLE;
               mem_en_d = 1'b0;
               if (!mem_valid) begin
                  bus_err_d = 1'b1;
               end
               if (state_q == ARB_BUSY_I) begin
                  if_done_d  = 1'b1;
                  if_rdata_d = mem_valid ? mem_rdata : '0;
               end else begin
                  d_done_d  = 1'b1;
                  d_rdata_d = (mem_valid && !mem_we_q) ? mem_rdata : '0;
               end
            end
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any access in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         starve_q    <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         if_done_q   <= if_done_d;
         d_done_q    <= d_done_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         bus_err_q   <= bus_err_d;
      end
   end

   // Sanity: fetches never write and only one requester completes at a time
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (mem_en_q && mem_we_q) begin
            assert (port_of(state_q) == PORT_D);
         end
         assert (!(if_done_q && d_done_q));
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign if_done   = if_done_q;
   assign d_done    = d_done_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign bus_err   = bus_err_q;

   assign if_stall = if_req & ~if_done_q;
   assign d_stall  = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: per-cycle vector table for the basic
// fetch/store/idle behaviour, plus sequences for starvation, the timeout
// boundary, the timeout abort and reset during an access.
module tb_mem_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int BE_W       = DATA_W / 8;
   localparam int STARVE_MAX = 4;
   localparam int TIMEOUT    = 64;

   logic              clk;
   logic              rst;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_done;
   logic              if_stall;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [BE_W-1:0]   d_be;
   logic [DATA_W-1:0] d_rdata;
   logic              d_done;
   logic              d_stall;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [BE_W-1:0]   mem_be;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_valid;
   logic              bus_err;

   mem_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .STARVE_MAX (STARVE_MAX),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_done   (if_done),
      .if_stall  (if_stall),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_be      (d_be),
      .d_rdata   (d_rdata),
      .d_done    (d_done),
      .d_stall   (d_stall),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_rdata (mem_rdata),
      .mem_valid (mem_valid),
      .bus_err   (bus_err)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One vector per clock cycle; every field is 32 bits wide for easy tables
   typedef struct {
      logic [31:0] if_req;
      logic [31:0] if_addr;
      logic [31:0] d_req;
      logic [31:0] d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [31:0] d_be;
      logic [31:0] mem_valid;
      logic [31:0] mem_rdata;
      logic [31:0] e_mem_en;
      logic [31:0] e_mem_we;
      logic [31:0] e_mem_addr;
      logic [31:0] e_mem_wdata;
      logic [31:0] e_mem_be;
      logic [31:0] e_if_done;
      logic [31:0] e_if_rdata;
      logic [31:0] e_d_done;
      logic [31:0] e_d_rdata;
      logic [31:0] e_if_stall;
      logic [31:0] e_d_stall;
      logic [31:0] e_bus_err;
   } vec_t;

   vec_t vecs[$];

   int checks_total  = 0;
   int checks_passed = 0;
   int cyc           = 0;

   // Behavioural memory used by the sequences
   logic [31:0] mem_arr [logic [31:0]];
   bit          mem_auto;
   int          mem_lat;
   int          mem_age;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks_total++;
      if (actual === expected) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h",
                  name, cyc, actual, expected);
      end
   endtask

   function automatic logic [31:0] memRead(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return a ^ 32'hA5A5_5A5A;
   endfunction

   // Answers mem_valid mem_lat cycles after the first mem_en cycle
   task automatic memModel();
      logic [31:0] w;
      mem_valid = 1'b0;
      mem_rdata = '0;
      if (mem_en) begin
         mem_age++;
         if (mem_age == mem_lat + 1) begin
            mem_valid = 1'b1;
            if (mem_we) begin
               w = memRead(mem_addr);
               for (int b = 0; b < BE_W; b++) begin
                  if (mem_be[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
               end
               mem_arr[mem_addr] = w;
               mem_rdata = 32'hFFFF_FFFF;
            end else begin
               mem_rdata = memRead(mem_addr);
            end
         end
      end else begin
         mem_age = 0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (mem_auto) memModel();
   endtask

   task automatic applyStimulus(input vec_t v);
      if_req    = v.if_req[0];
      if_addr   = v.if_addr;
      d_req     = v.d_req[0];
      d_we      = v.d_we[0];
      d_addr    = v.d_addr;
      d_wdata   = v.d_wdata;
      d_be      = v.d_be[BE_W-1:0];
      mem_valid = v.mem_valid[0];
      mem_rdata = v.mem_rdata;
   endtask

   task automatic checkVector(input int r, input vec_t v);
      checkOutput($sformatf("row%0d mem_en", r),   32'(mem_en),   v.e_mem_en);
      checkOutput($sformatf("row%0d if_done", r),  32'(if_done),  v.e_if_done);
      checkOutput($sformatf("row%0d d_done", r),   32'(d_done),   v.e_d_done);
      checkOutput($sformatf("row%0d if_stall", r), 32'(if_stall), v.e_if_stall);
      checkOutput($sformatf("row%0d d_stall", r),  32'(d_stall),  v.e_d_stall);
      checkOutput($sformatf("row%0d bus_err", r),  32'(bus_err),  v.e_bus_err);
      if (v.e_mem_en[0]) begin
         checkOutput($sformatf("row%0d mem_we", r),   32'(mem_we),   v.e_mem_we);
         checkOutput($sformatf("row%0d mem_addr", r), mem_addr,      v.e_mem_addr);
         checkOutput($sformatf("row%0d mem_be", r),   32'(mem_be),   v.e_mem_be);
         if (v.e_mem_we[0]) begin
            checkOutput($sformatf("row%0d mem_wdata", r), mem_wdata, v.e_mem_wdata);
         end
      end
      if (v.e_if_done[0]) begin
         checkOutput($sformatf("row%0d if_rdata", r), if_rdata, v.e_if_rdata);
      end
      if (v.e_d_done[0]) begin
         checkOutput($sformatf("row%0d d_rdata", r), d_rdata, v.e_d_rdata);
      end
   endtask

   initial begin
      int d_cnt;
      int fetch_at;
      int done_k;
      int en_cycles;

      rst       = 1'b1;
      if_req    = 1'b0;
      if_addr   = '0;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = '0;
      d_wdata   = '0;
      d_be      = '0;
      mem_valid = 1'b0;
      mem_rdata = '0;
      mem_auto  = 1'b0;
      mem_lat   = 2;
      mem_age   = 0;

      // Reset state
      repeat (3) tick();
      checkOutput("reset mem_en",   32'(mem_en),   32'd0);
      checkOutput("reset mem_addr", mem_addr,      32'd0);
      checkOutput("reset mem_be",   32'(mem_be),   32'd0);
      checkOutput("reset if_done",  32'(if_done),  32'd0);
      checkOutput("reset d_done",   32'(d_done),   32'd0);
      checkOutput("reset if_rdata", if_rdata,      32'd0);
      checkOutput("reset d_rdata",  d_rdata,       32'd0);
      checkOutput("reset bus_err",  32'(bus_err),  32'd0);
      rst = 1'b0;

      //              ifr ifaddr  dr dwe daddr   dwdata        dbe   mv mrdata          en we maddr   mwdata        mbe   ifd ifrdata        dd drdata ifs ds be
      // Fetch only, memory latency 2
      vecs.push_back('{0, 0,      0, 0, 0,      0,            0,    0, 0,              0, 0, 0,      0,            0,    0, 0,              0, 0,     0, 0, 0});
      vecs.push_back('{1, 'h10,   0, 0, 0,      0,            0,    0, 0,              0, 0, 0,      0,            0,    0, 0,              0, 0,     1, 0, 0});
      vecs.push_back('{1, 'h10,   0, 0, 0,      0,            0,    0, 0,              1, 0, 'h10,   0,            'hF,  0, 0,              0, 0,     1, 0, 0});
      vecs.push_back('{1, 'h10,   0, 0, 0,      0,            0,    0, 0,              1, 0, 'h10,   0,            'hF,  0, 0,              0, 0,     1, 0, 0});
      vecs.push_back('{1, 'h10,   0, 0, 0,      0,            0,    1, 'h00500093,     1, 0, 'h10,   0,            'hF,  0, 0,              0, 0,     1, 0, 0});
      vecs.push_back('{0, 0,      0, 0, 0,      0,            0,    0, 0,              0, 0, 0,      0,            0,    1, 'h00500093,     0, 0,     0, 0, 0});
      vecs.push_back('{0, 0,      0, 0, 0,      0,            0,    0, 0,              0, 0, 0,      0,            0,    0, 0,              0, 0,     0, 0, 0});
      // Simultaneous store and fetch: data first, then fetch
      vecs.push_back('{1, 'h20,   1, 1, 'h100,  'hDEADBEEF,   'hF,  0, 0,              0, 0, 0,      0,            0,    0, 0,              0, 0,     1, 1, 0});
      vecs.push_back('{1, 'h20,   1, 1, 'h100,  'hDEADBEEF,   'hF,  0, 0,              1, 1, 'h100,  'hDEADBEEF,   'hF,  0, 0,              0, 0,     1, 1, 0});
      vecs.push_back('{1, 'h20,   1, 1, 'h100,  'hDEADBEEF,   'hF,  1, 'h12345678,     1, 1, 'h100,  'hDEADBEEF,   'hF,  0, 0,              0, 0,     1, 1, 0});
      vecs.push_back('{1, 'h20,   0, 0, 0,      0,            0,    0, 0,              0, 0, 0,      0,            0,    0, 0,              1, 0,     1, 0, 0});
      vecs.push_back('{1, 'h20,   0, 0, 0,      0,            0,    0, 0,              1, 0, 'h20,   0,            'hF,  0, 0,              0, 0,     1, 0, 0});
      vecs.push_back('{1, 'h20,   0, 0, 0,      0,            0,    1, 'hCAFEF00D,     1, 0, 'h20,   0,            'hF,  0, 0,              0, 0,     1, 0, 0});
      vecs.push_back('{0, 0,      0, 0, 0,      0,            0,    0, 0,              0, 0, 0,      0,            0,    1, 'hCAFEF00D,     0, 0,     0, 0, 0});
      // mem_valid while idle is ignored
      vecs.push_back('{0, 0,      0, 0, 0,      0,            0,    1, 'h77777777,     0, 0, 0,      0,            0,    0, 0,              0, 0,     0, 0, 0});
      vecs.push_back('{0, 0,      0, 0, 0,      0,            0,    0, 0,              0, 0, 0,      0,            0,    0, 0,              0, 0,     0, 0, 0});
      vecs.push_back('{0, 0,      0, 0, 0,      0,            0,    0, 0,              0, 0, 0,      0,            0,    0, 0,              0, 0,     0, 0, 0});
      // Partial-byte store answered in its first bus cycle
      vecs.push_back('{0, 0,      1, 1, 'h104,  'h0000ABCD,   'h3,  0, 0,              0, 0, 0,      0,            0,    0, 0,              0, 0,     0, 1, 0});
      vecs.push_back('{0, 0,      1, 1, 'h104,  'h0000ABCD,   'h3,  1, 'h55555555,     1, 1, 'h104,  'h0000ABCD,   'h3,  0, 0,              0, 0,     0, 1, 0});
      vecs.push_back('{0, 0,      0, 0, 0,      0,            0,    0, 0,              0, 0, 0,      0,            0,    0, 0,              1, 0,     0, 0, 0});
      vecs.push_back('{0, 0,      0, 0, 0,      0,            0,    0, 0,              0, 0, 0,      0,            0,    0, 0,              0, 0,     0, 0, 0});

      for (int r = 0; r < vecs.size(); r++) begin
         tick();
         applyStimulus(vecs[r]);
         #1;
         checkVector(r, vecs[r]);
      end

      // Starvation: continuous loads with a pending fetch -> D D D D I D
      mem_auto  = 1'b1;
      mem_lat   = 1;
      mem_valid = 1'b0;
      tick();
      if_req  = 1'b1;
      if_addr = 32'h40;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 32'h200;
      d_wdata = '0;
      d_be    = '0;
      d_cnt    = 0;
      fetch_at = -1;
      for (int k = 0; k < 200 && d_cnt < 5; k++) begin
         tick();
         if (d_done) begin
            checkOutput("starve d_rdata", d_rdata, memRead(32'h200));
            checkOutput("starve d_stall at done", 32'(d_stall), 32'd0);
            checkOutput("starve mem_en at done", 32'(mem_en), 32'd0);
            d_cnt++;
            if (d_cnt == 5) d_req = 1'b0;
         end
         if (if_done) begin
            checkOutput("starve if_rdata", if_rdata, memRead(32'h40));
            fetch_at = d_cnt;
            if_req   = 1'b0;
         end
      end
      checkOutput("starve fetch after data count", 32'(fetch_at), 32'd4);
      checkOutput("starve total data completions", 32'(d_cnt), 32'd5);
      tick();
      tick();
      mem_auto = 1'b0;

      // mem_valid on the terminal count cycle is a normal completion
      tick();
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h300;
      done_k = -1;
      for (int k = 1; k <= 100 && done_k < 0; k++) begin
         tick();
         mem_valid = (k == TIMEOUT);
         mem_rdata = (k == TIMEOUT) ? 32'h13579BDF : 32'h0;
         if (k == TIMEOUT) checkOutput("late valid mem_en held", 32'(mem_en), 32'd1);
         if (d_done) begin
            done_k = k;
            checkOutput("late valid d_rdata", d_rdata, 32'h13579BDF);
            checkOutput("late valid bus_err", 32'(bus_err), 32'd0);
            d_req = 1'b0;
         end
      end
      checkOutput("late valid done cycle", 32'(done_k), 32'(TIMEOUT + 1));
      tick();

      // Memory never answers: abort after TIMEOUT bus cycles
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h304;
      done_k    = -1;
      en_cycles = 0;
      for (int k = 1; k <= 100 && done_k < 0; k++) begin
         tick();
         mem_valid = 1'b0;
         if (mem_en) en_cycles++;
         if (d_done) begin
            done_k = k;
            checkOutput("timeout d_rdata", d_rdata, 32'h0);
            checkOutput("timeout bus_err", 32'(bus_err), 32'd1);
            checkOutput("timeout mem_en at done", 32'(mem_en), 32'd0);
            d_req = 1'b0;
         end
      end
      checkOutput("timeout done cycle", 32'(done_k), 32'(TIMEOUT + 1));
      checkOutput("timeout mem_en cycles", 32'(en_cycles), 32'(TIMEOUT));
      repeat (3) tick();
      checkOutput("timeout bus_err sticky", 32'(bus_err), 32'd1);

      // Reset one cycle before mem_valid during a fetch
      if_req  = 1'b1;
      if_addr = 32'h50;
      tick();
      checkOutput("rst pre mem_en", 32'(mem_en), 32'd1);
      tick();
      rst    = 1'b1;
      if_req = 1'b0;
      tick();
      rst       = 1'b0;
      mem_valid = 1'b1;
      mem_rdata = 32'h99999999;
      #1;
      checkOutput("rst mem_en",    32'(mem_en),   32'd0);
      checkOutput("rst mem_addr",  mem_addr,      32'd0);
      checkOutput("rst mem_be",    32'(mem_be),   32'd0);
      checkOutput("rst mem_we",    32'(mem_we),   32'd0);
      checkOutput("rst if_done",   32'(if_done),  32'd0);
      checkOutput("rst d_done",    32'(d_done),   32'd0);
      checkOutput("rst if_rdata",  if_rdata,      32'd0);
      checkOutput("rst bus_err",   32'(bus_err),  32'd0);
      checkOutput("rst if_stall",  32'(if_stall), 32'd0);
      tick();
      mem_valid = 1'b0;
      checkOutput("rst no late if_done", 32'(if_done), 32'd0);
      checkOutput("rst stays idle",      32'(mem_en),  32'd0);
      tick();
      checkOutput("rst no if_done after", 32'(if_done), 32'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
